// File: rtl/lfsr.sv
// rtl/lfsr.sv - 16-bit maximal-length Fibonacci LFSR with lockup recovery
module lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rand_bit,
    output logic [4:0] data
);

    // Power-up value comes from the register initialiser so the generator runs without a reset pulse.
    logic [15:0] state = SEED;
    logic        fb;
    logic [15:0] next_state;

    always_comb begin
        fb         = state[15] ^ state[13] ^ state[12] ^ state[10];
        next_state = {state[14:0], fb};
    end

    // The all-zero state is a fixed point of the shift, so it is escaped by reloading SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (state == 16'h0000) begin
            state <= SEED;
        end else begin
            state <= next_state;
        end
    end

    assign rand_bit = state[0];
    assign data     = state[4:0];

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - directed self-checking bench for lfsr
module tb_lfsr;

    logic       clk;
    logic       rst;
    logic       rand_bit;
    logic [4:0] data;
    logic       zero_rand_bit;
    logic [4:0] zero_data;

    int checks   = 0;
    int failures = 0;

    lfsr dut (
        .clk      (clk),
        .rst      (rst),
        .rand_bit (rand_bit),
        .data     (data)
    );

    lfsr #(.SEED(16'h0000)) dut_zero (
        .clk      (clk),
        .rst      (rst),
        .rand_bit (zero_rand_bit),
        .data     (zero_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pu_state [3] = '{16'h59C3, 16'hB387, 16'h670F};
    logic [4:0]  pu_data  [3] = '{5'd3, 5'd7, 5'd15};

    logic [15:0] exp_state;
    logic [31:0] seen;
    logic        early_return;
    logic        hit_zero;
    logic        fb;

    initial begin
        rst = 1'b0;

        // Power-up without any reset pulse
        #1;
        check_eq("powerup_state", {16'h0, dut.state}, 32'hACE1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("pu_state", {16'h0, dut.state}, {16'h0, pu_state[i]});
            check_eq("pu_data", {27'h0, data}, {27'h0, pu_data[i]});
            check_eq("pu_rand_bit", {31'h0, rand_bit}, 32'h1);
        end

        // rst pulse between edges must not affect the sequence
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        check_eq("glitch_state", {16'h0, dut.state}, 32'hCE1E);

        // Two-cycle synchronous reset mid-run
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_state", {16'h0, dut.state}, 32'hACE1);
            check_eq("rst_data", {27'h0, data}, 32'h1);
            check_eq("rst_rand_bit", {31'h0, rand_bit}, 32'h1);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        check_eq("post_rst_state", {16'h0, dut.state}, 32'h59C3);

        // Illegal zero seed stays locked at zero
        for (int i = 0; i < 3; i++) begin
            check_eq("zero_seed_data", {27'h0, zero_data}, 32'h0);
            check_eq("zero_seed_bit", {31'h0, zero_rand_bit}, 32'h0);
            step();
        end

        // Lockup recovery from a deposited all-zero state
        @(negedge clk);
        force dut.state = 16'h0000;
        #1;
        release dut.state;
        #1;
        check_eq("deposit_zero", {16'h0, dut.state}, 32'h0);
        step();
        check_eq("lockup_reload", {16'h0, dut.state}, 32'hACE1);
        step();
        check_eq("lockup_step", {16'h0, dut.state}, 32'h59C3);

        // Full period from SEED
        @(negedge clk);
        rst = 1'b1;
        step();
        check_eq("period_start", {16'h0, dut.state}, 32'hACE1);
        @(negedge clk);
        rst = 1'b0;
        early_return = 1'b0;
        hit_zero     = 1'b0;
        for (int i = 1; i <= 65535; i++) begin
            step();
            if (dut.state == 16'hACE1 && i < 65535) early_return = 1'b1;
            if (dut.state == 16'h0000) hit_zero = 1'b1;
        end
        check_eq("period_end", {16'h0, dut.state}, 32'hACE1);
        check_eq("period_early", {31'h0, early_return}, 32'h0);
        check_eq("period_zero", {31'h0, hit_zero}, 32'h0);

        // Output mapping and data coverage over 1000 cycles
        exp_state = 16'hACE1;
        seen      = 32'h0;
        for (int i = 0; i < 1000; i++) begin
            fb        = exp_state[15] ^ exp_state[13] ^ exp_state[12] ^ exp_state[10];
            exp_state = {exp_state[14:0], fb};
            step();
            check_eq("map_state", {16'h0, dut.state}, {16'h0, exp_state});
            check_eq("map_data", {27'h0, data}, {27'h0, exp_state[4:0]});
            check_eq("map_rand_bit", {31'h0, rand_bit}, {31'h0, exp_state[0]});
            seen[data] = 1'b1;
        end
        check_eq("data_coverage", seen, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
